man_mul_iter: RTL



---
 rtl/fpu_mul_pkg.sv | 21 ++
 rtl/man_norm_grs.sv | 43 ++++
 rtl/man_mul_iter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared definitions for the single-precision FPU multiplier datapath.
//   - man_mul_state_e : control states of the iterative mantissa multiplier
//   - SIZE_MAN_DEFAULT: mantissa width including the hidden bit
//   - cnt_width()     : width of the iteration counter for a given mantissa width
package fpu_mul_pkg;

  localparam int unsigned SIZE_MAN_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    DONE
  } man_mul_state_e;

  // Counter must hold 0..SIZE_MAN-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned size_man);
    return (size_man > 1) ? $clog2(size_man) : 1;
  endfunction

endpackage : fpu_mul_pkg

// File: rtl/man_norm_grs.sv
// Combinational normalisation of a 2*SIZE_MAN-bit mantissa product with
// guard/sticky extraction and a round-to-nearest-even increment request.
// Ports:
//   i_prod         full product of two SIZE_MAN-bit mantissas
//   o_man          normalised, truncated SIZE_MAN-bit mantissa
//   o_rounding_bit RNE increment request (guard & (sticky | lsb))
//   o_exp_inc      product was in [2,4); exponent needs +1
module man_norm_grs
  import fpu_mul_pkg::*;
#(
  parameter int unsigned SIZE_MAN = SIZE_MAN_DEFAULT
) (
  input  logic [2*SIZE_MAN-1:0] i_prod,
  output logic [SIZE_MAN-1:0]   o_man,
  output logic                  o_rounding_bit,
  output logic                  o_exp_inc
);

  logic w_guard;
  logic w_sticky;

  // Products lacking both top bits (zero/denormal inputs) take the second
  // branch unchanged; no special casing.
  always_comb begin
    o_man     = '0;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    o_exp_inc = 1'b0;
    if (i_prod[2*SIZE_MAN-1]) begin
      o_man     = i_prod[2*SIZE_MAN-1:SIZE_MAN];
      w_guard   = i_prod[SIZE_MAN-1];
      w_sticky  = |i_prod[SIZE_MAN-2:0];
      o_exp_inc = 1'b1;
    end else begin
      o_man     = i_prod[2*SIZE_MAN-2:SIZE_MAN-1];
      w_guard   = i_prod[SIZE_MAN-2];
      w_sticky  = |i_prod[SIZE_MAN-3:0];
      o_exp_inc = 1'b0;
    end
    o_rounding_bit = w_guard & (w_sticky | o_man[0]);
  end

endmodule : man_norm_grs

// File: rtl/man_mul_iter.sv
// Iterative radix-2 shift-add mantissa multiplier. Takes SIZE_MAN cycles to
// form the full product, one cycle to register the normalised result, then
// holds it until the downstream rounding stage accepts it.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid/o_ready   operand handshake (o_ready high only in IDLE)
//   i_man_a, i_man_b  multiplicand / multiplier mantissas (hidden bit included)
//   o_valid/i_ready   result handshake, result held until consumed
//   o_man             normalised, truncated mantissa
//   o_rounding_bit    RNE increment request
//   o_exp_inc         exponent must be incremented by one
module man_mul_iter
  import fpu_mul_pkg::*;
#(
  parameter int unsigned SIZE_MAN = SIZE_MAN_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_rounding_bit,
  output logic                o_exp_inc
);

  localparam int unsigned CW = cnt_width(SIZE_MAN);
  localparam logic [CW-1:0] LAST_CNT = CW'(SIZE_MAN - 1);

  man_mul_state_e r_state;
  man_mul_state_e w_next;

  logic [SIZE_MAN-1:0]   r_a;
  logic [2*SIZE_MAN:0]   r_p;
  logic [CW-1:0]         r_cnt;
  logic [SIZE_MAN-1:0]   r_man;
  logic                  r_rounding_bit;
  logic                  r_exp_inc;

  logic [SIZE_MAN:0]     w_upper;
  logic [2*SIZE_MAN:0]   w_p_next;
  logic [SIZE_MAN-1:0]   w_norm_man;
  logic                  w_norm_round;
  logic                  w_norm_exp_inc;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_valid)           w_next = CALC;
      CALC: if (r_cnt == LAST_CNT) w_next = NORM;
      NORM:                        w_next = DONE;
      DONE: if (i_ready)           w_next = IDLE;
      default:                     w_next = IDLE;
    endcase
  end

  // Handshake outputs decode from state only
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE:    o_ready = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  // One shift-add step: conditionally add A into the upper SIZE_MAN+1 bits,
  // then shift the whole register right by one.
  always_comb begin
    w_upper  = r_p[2*SIZE_MAN:SIZE_MAN] + (r_p[0] ? {1'b0, r_a} : '0);
    w_p_next = {1'b0, w_upper, r_p[SIZE_MAN-1:1]};
  end

  man_norm_grs #(
    .SIZE_MAN (SIZE_MAN)
  ) u_norm (
    .i_prod         (r_p[2*SIZE_MAN-1:0]),
    .o_man          (w_norm_man),
    .o_rounding_bit (w_norm_round),
    .o_exp_inc      (w_norm_exp_inc)
  );

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a            <= '0;
      r_p            <= '0;
      r_cnt          <= '0;
      r_man          <= '0;
      r_rounding_bit <= 1'b0;
      r_exp_inc      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_a   <= i_man_a;
            r_p   <= {{(SIZE_MAN+1){1'b0}}, i_man_b};
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_p   <= w_p_next;
          r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
        NORM: begin
          r_man          <= w_norm_man;
          r_rounding_bit <= w_norm_round;
          r_exp_inc      <= w_norm_exp_inc;
        end
        default: ;
      endcase
    end
  end

  assign o_man          = r_man;
  assign o_rounding_bit = r_rounding_bit;
  assign o_exp_inc      = r_exp_inc;

endmodule : man_mul_iter
